// File: rtl/spi_cs_sequencer_if.sv
// Bundle between the SoC-side byte stream, the sequencer and the SPI byte master.
// The slave modport is the sequencer's view; master is the view of whoever
// drives the SoC side and models the byte master.
interface spi_cs_sequencer_if #(
  parameter int CW = 2
);
  // SoC side
  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  // Byte master side
  logic [7:0]    o_M_TX_Byte;
  logic          o_M_TX_DV;
  logic          i_M_TX_Ready;
  logic          i_M_RX_DV;
  logic [7:0]    i_M_RX_Byte;
  // Pad
  logic          o_SPI_CS_n;

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    output o_M_TX_Byte, o_M_TX_DV,
    input  i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    output o_SPI_CS_n
  );

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    input  o_M_TX_Byte, o_M_TX_DV,
    output i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    input  o_SPI_CS_n
  );
endinterface

// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer in front of a byte-level SPI master: holds CS low
// across a multi-byte transfer, enforces a CS-high gap between transfers and
// tags received bytes with their index inside the transfer.
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  spi_cs_sequencer_if.slave     bus
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int GW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES_PER_CS);
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_INACTIVE_CLKS - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRANSFER = 2'd1;
  localparam logic [1:0] CS_GAP   = 2'd2;

  logic [1:0]    state_reg;
  logic [CW-1:0] remaining_reg;
  logic [GW-1:0] gap_reg;
  logic          sent_reg;
  logic          cs_n_reg;
  logic          m_tx_dv_reg;
  logic [7:0]    m_tx_byte_reg;
  logic          rx_dv_reg;
  logic [7:0]    rx_byte_reg;
  logic [CW-1:0] rx_count_reg;
  logic [CW-1:0] rx_idx_reg;

  logic          master_free;
  logic          tx_ready;
  logic          accept;
  logic          start;
  logic          fwd;
  logic [CW-1:0] sat_count;
  logic [CW-1:0] first_remaining;

  // The byte master's ready lags our DV by a cycle; sent_reg and the DV
  // register keep us from mistaking that stale ready for a free master.
  assign master_free = bus.i_M_TX_Ready & ~sent_reg & ~m_tx_dv_reg;

  // Accept, start and saturated byte-count decode
  always_comb begin
    tx_ready = 1'b0;
    case (state_reg)
      IDLE:     tx_ready = master_free;
      TRANSFER: tx_ready = master_free & (remaining_reg != '0);
      default:  tx_ready = 1'b0;
    endcase
    accept          = bus.i_TX_DV & tx_ready;
    start           = accept & (state_reg == IDLE) & (bus.i_TX_Count != '0);
    fwd             = accept & (state_reg == TRANSFER);
    sat_count       = (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;
    first_remaining = sat_count - 1'b1;
  end

  // Transfer FSM: CS framing, byte forwarding and the CS-high gap
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      gap_reg       <= '0;
      sent_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      m_tx_dv_reg   <= 1'b0;
      m_tx_byte_reg <= 8'h00;
    end else begin
      m_tx_dv_reg <= start | fwd;
      if (start | fwd) begin
        m_tx_byte_reg <= bus.i_TX_Byte;
        sent_reg      <= 1'b1;
      end else if (!bus.i_M_TX_Ready) begin
        sent_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            cs_n_reg      <= 1'b0;
            remaining_reg <= first_remaining;
            state_reg     <= TRANSFER;
          end
        end
        TRANSFER: begin
          if (fwd) begin
            remaining_reg <= remaining_reg - 1'b1;
          end else if ((remaining_reg == '0) && master_free) begin
            cs_n_reg  <= 1'b1;
            gap_reg   <= GAP_LOAD;
            state_reg <= CS_GAP;
          end
        end
        CS_GAP: begin
          if (gap_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            gap_reg <= gap_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Receive path: register each byte with its index, restart index per transfer
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rx_dv_reg    <= 1'b0;
      rx_byte_reg  <= 8'h00;
      rx_count_reg <= '0;
      rx_idx_reg   <= '0;
    end else begin
      rx_dv_reg <= bus.i_M_RX_DV;
      if (bus.i_M_RX_DV) begin
        rx_byte_reg  <= bus.i_M_RX_Byte;
        rx_count_reg <= rx_idx_reg;
      end
      if (start) begin
        rx_idx_reg <= '0;
      end else if (bus.i_M_RX_DV) begin
        rx_idx_reg <= rx_idx_reg + 1'b1;
      end
    end
  end

  assign bus.o_TX_Ready  = tx_ready;
  assign bus.o_M_TX_DV   = m_tx_dv_reg;
  assign bus.o_M_TX_Byte = m_tx_byte_reg;
  assign bus.o_RX_DV     = rx_dv_reg;
  assign bus.o_RX_Byte   = rx_byte_reg;
  assign bus.o_RX_Count  = rx_count_reg;
  assign bus.o_SPI_CS_n  = cs_n_reg;
endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Bench for spi_cs_sequencer with a loopback byte-master model and an RX scoreboard.
module tb_spi_cs_sequencer;
  localparam int MAXB = 2;
  localparam int GAP  = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spi_cs_sequencer_if #(.CW(CW)) bus ();

  spi_cs_sequencer #(
    .MAX_BYTES_PER_CS(MAXB),
    .CS_INACTIVE_CLKS(GAP)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_l),
    .bus    (bus)
  );

  typedef struct packed {
    logic [CW-1:0] idx;
    logic [7:0]    b;
  } rx_t;
  rx_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int mdv_cnt = 0;
  int cs_low_cyc = 0;
  int cs_viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Byte master model: takes a byte, drops ready, loops it back as RX, then re-raises ready
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_shift;
  always @(posedge clk) begin
    bus.i_M_RX_DV <= 1'b0;
    if (!rst_l) begin
      bus.i_M_TX_Ready <= 1'b0;
      bus.i_M_RX_Byte  <= 8'h00;
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_shift <= 8'h00;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        bus.i_M_RX_DV   <= 1'b1;
        bus.i_M_RX_Byte <= m_shift;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (bus.o_M_TX_DV && bus.i_M_TX_Ready) begin
      bus.i_M_TX_Ready <= 1'b0;
      m_busy  <= 1'b1;
      m_shift <= bus.o_M_TX_Byte;
      m_cnt   <= 5;
    end else begin
      bus.i_M_TX_Ready <= 1'b1;
    end
  end

  // Monitor: pop the scoreboard on each RX pulse, count TX pulses and CS-low cycles
  always @(negedge clk) begin
    if (bus.o_M_TX_DV === 1'b1) begin
      mdv_cnt++;
      if (bus.o_SPI_CS_n !== 1'b0) cs_viol++;
    end
    if (bus.o_SPI_CS_n === 1'b0) cs_low_cyc++;
    if (bus.o_RX_DV === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rx_unexpected", 32'(bus.o_RX_Byte), 32'h1_0000);
      end else begin
        rx_t e;
        e = exp_q.pop_front();
        $display("RX byte=0x%02h idx=%0d (expected 0x%02h idx=%0d)", bus.o_RX_Byte, bus.o_RX_Count, e.b, e.idx);
        check("rx_byte", 32'(bus.o_RX_Byte), 32'(e.b));
        check("rx_count", 32'(bus.o_RX_Count), 32'(e.idx));
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.o_TX_Ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(bus.o_TX_Ready), 32'd1);
  endtask

  // Offer one byte once the sequencer is ready; queue its expected loopback
  task automatic send(input logic [7:0] b, input logic [CW-1:0] cnt, input logic [CW-1:0] idx,
                      input string tag);
    wait_ready(tag);
    bus.i_TX_Byte  = b;
    bus.i_TX_Count = cnt;
    bus.i_TX_DV    = 1'b1;
    if (bus.o_TX_Ready === 1'b1) exp_q.push_back(rx_t'{idx, b});
    $display("TX %s byte=0x%02h count=%0d", tag, b, cnt);
    @(negedge clk);
    bus.i_TX_DV = 1'b0;
  endtask

  task automatic wait_cs_high(input string tag);
    int n = 0;
    while (bus.o_SPI_CS_n !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cs_high"}, 32'(bus.o_SPI_CS_n), 32'd1);
  endtask

  task automatic wait_q_empty(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rx_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    int c0;
    int gap_cnt;
    int n;

    // Reset with a DV held high: nothing may leak out
    rst_l = 1'b0;
    bus.i_TX_DV = 1'b1;
    bus.i_TX_Count = CW'(1);
    bus.i_TX_Byte = 8'h55;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.o_SPI_CS_n), 32'd1);
    check("rst_m_tx_dv", 32'(bus.o_M_TX_DV), 32'd0);
    check("rst_rx_dv", 32'(bus.o_RX_DV), 32'd0);
    check("rst_tx_ready", 32'(bus.o_TX_Ready), 32'd0);
    check("rst_rx_count", 32'(bus.o_RX_Count), 32'd0);
    check("rst_m_tx_byte", 32'(bus.o_M_TX_Byte), 32'd0);
    bus.i_TX_DV = 1'b0;
    rst_l = 1'b1;
    wait_ready("post_rst");
    check("post_rst_no_dv", 32'(mdv_cnt), 32'd0);

    // Two-byte transfer with loopback
    m0 = mdv_cnt;
    send(8'hA5, CW'(2), CW'(0), "t2_b0");
    check("t2_cs_low", 32'(bus.o_SPI_CS_n), 32'd0);
    check("t2_m_dv", 32'(bus.o_M_TX_DV), 32'd1);
    check("t2_m_byte", 32'(bus.o_M_TX_Byte), 32'hA5);
    check("t2_busy_not_ready", 32'(bus.o_TX_Ready), 32'd0);
    send(8'h3C, CW'(2), CW'(1), "t2_b1");
    wait_cs_high("t2");
    check("t2_rx_before_cs", 32'(exp_q.size()), 32'd0);
    check("t2_dv_pulses", 32'(mdv_cnt - m0), 32'd2);

    // Back-to-back single-byte transfers with the next DV held waiting
    m0 = mdv_cnt;
    send(8'h5A, CW'(1), CW'(0), "t3_a");
    bus.i_TX_Byte = 8'h96;
    bus.i_TX_Count = CW'(1);
    bus.i_TX_DV = 1'b1;
    gap_cnt = 0;
    n = 0;
    while (bus.o_TX_Ready !== 1'b1 && n < 400) begin
      if (bus.o_SPI_CS_n === 1'b1) gap_cnt++;
      @(negedge clk);
      n++;
    end
    check("t3_ready", 32'(bus.o_TX_Ready), 32'd1);
    exp_q.push_back(rx_t'{CW'(0), 8'h96});
    $display("TX t3_b byte=0x96 count=1 (held) gap=%0d", gap_cnt);
    @(negedge clk);
    bus.i_TX_DV = 1'b0;
    check("t3_gap_cycles", 32'(gap_cnt), 32'(GAP));
    wait_cs_high("t3");
    wait_q_empty("t3");
    check("t3_dv_pulses", 32'(mdv_cnt - m0), 32'd2);

    // Zero count is ignored
    wait_ready("t4");
    m0 = mdv_cnt;
    c0 = cs_low_cyc;
    bus.i_TX_Byte = 8'h11;
    bus.i_TX_Count = CW'(0);
    bus.i_TX_DV = 1'b1;
    $display("TX t4 byte=0x11 count=0");
    @(negedge clk);
    bus.i_TX_DV = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_no_dv", 32'(mdv_cnt - m0), 32'd0);
    check("t4_no_cs", 32'(cs_low_cyc - c0), 32'd0);
    check("t4_still_idle_ready", 32'(bus.o_TX_Ready), 32'd1);

    // Count 3 saturates to 2, with an illegal DV while the master is busy
    m0 = mdv_cnt;
    send(8'hC3, CW'(3), CW'(0), "t5_b0");
    check("t5_not_ready", 32'(bus.o_TX_Ready), 32'd0);
    bus.i_TX_Byte = 8'hEE;
    bus.i_TX_Count = CW'(1);
    bus.i_TX_DV = 1'b1;
    $display("TX t5_illegal byte=0xEE while not ready");
    @(negedge clk);
    bus.i_TX_DV = 1'b0;
    send(8'h7E, CW'(3), CW'(1), "t5_b1");
    wait_cs_high("t5");
    wait_q_empty("t5");
    wait_ready("t5_after");
    repeat (10) @(negedge clk);
    check("t5_dv_pulses", 32'(mdv_cnt - m0), 32'd2);
    check("t5_cs_stays_high", 32'(bus.o_SPI_CS_n), 32'd1);

    // Reset in the middle of a two-byte transfer, then a clean single byte
    m0 = mdv_cnt;
    send(8'h81, CW'(2), CW'(0), "t6_b0");
    wait_q_empty("t6_first");
    check("t6_cs_low_mid", 32'(bus.o_SPI_CS_n), 32'd0);
    rst_l = 1'b0;
    @(negedge clk);
    check("t6_rst_cs_high", 32'(bus.o_SPI_CS_n), 32'd1);
    check("t6_rst_not_ready", 32'(bus.o_TX_Ready), 32'd0);
    rst_l = 1'b1;
    send(8'h24, CW'(1), CW'(0), "t6_after");
    wait_cs_high("t6");
    wait_q_empty("t6");
    check("t6_dv_pulses", 32'(mdv_cnt - m0), 32'd2);

    check("cs_low_on_every_dv", 32'(cs_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
Transaction-level front end that sits directly upstream of the byte-level SPI master and drives its byte handshake (TX byte, TX data-valid, TX ready, RX data-valid, RX byte).
It takes a byte count plus a stream of TX bytes from the SoC bus side and feeds them to the byte master back-to-back.
It holds the active-low chip select low for the whole multi-byte transfer and enforces a minimum CS-high gap between transfers.
Received bytes are returned upstream with their index within the transfer.

Parameters:
MAX_BYTES_PER_CS, 2, maximum bytes in one CS-low transfer (>=1).
CS_INACTIVE_CLKS, 1, minimum i_Clk cycles CS stays high after a transfer ends (>=1).
CW, $clog2(MAX_BYTES_PER_CS+1), derived width of count ports (localparam).

Ports:
i_Clk  in  1  system clock, single clock domain.
i_Rst_L  in  1  reset, synchronous, active-low.
i_TX_Count  in  CW  bytes in the transfer; sampled only on the first i_TX_DV of a transfer.
i_TX_Byte  in  8  byte to send.
i_TX_DV  in  1  one-cycle pulse; accepted only while o_TX_Ready=1.
o_TX_Ready  out  1  sequencer can accept the next byte.
o_RX_Count  out  CW  index (0-based) of the byte on o_RX_Byte.
o_RX_DV  out  1  one-cycle pulse, received byte valid.
o_RX_Byte  out  8  received byte.
o_M_TX_Byte  out  8  to byte master TX byte input.
o_M_TX_DV  out  1  to byte master TX data-valid (one-cycle pulse).
i_M_TX_Ready  in  1  from byte master TX ready.
i_M_RX_DV  in  1  from byte master RX data-valid.
i_M_RX_Byte  in  8  from byte master RX byte.
o_SPI_CS_n  out  1  chip select to pad, active low.

Behaviour:
- Reset (i_Rst_L=0 at a rising edge): state=IDLE; o_SPI_CS_n=1; o_TX_Ready=0; o_M_TX_DV=0; o_M_TX_Byte=0; o_RX_DV=0; o_RX_Byte=0; o_RX_Count=0; internal remaining-count=0; sent flag=0; gap counter=0.
- Reset mid-transfer aborts immediately. CS returns high on that edge. The byte master shares i_Rst_L.
- States: IDLE, TRANSFER, CS_GAP.
- Sent flag: set when o_M_TX_DV is issued; cleared on the first cycle i_M_TX_Ready=0 is observed. This handles the one-cycle lag before the byte master drops ready.
- Master free = i_M_TX_Ready & ~sent & ~o_M_TX_DV.
- o_TX_Ready (combinational from registers and i_M_TX_Ready):
  - IDLE: master free.
  - TRANSFER: master free & remaining>0.
  - CS_GAP: 0.
- IDLE, i_TX_DV=1 & o_TX_Ready=1 & i_TX_Count!=0:
  - Next edge: o_SPI_CS_n=0, o_M_TX_Byte=i_TX_Byte, o_M_TX_DV=1 for one cycle.
  - remaining=min(i_TX_Count,MAX_BYTES_PER_CS)-1; RX index reset to 0; go to TRANSFER.
  - i_TX_Count > MAX_BYTES_PER_CS saturates to MAX_BYTES_PER_CS.
- IDLE, i_TX_DV with i_TX_Count=0: ignored. No CS activity, state unchanged.
- i_TX_DV while o_TX_Ready=0: ignored and dropped, in every state.
- TRANSFER, accepted i_TX_DV: forward byte to o_M_TX_Byte/o_M_TX_DV on the next edge; remaining decrements by 1. Latency i_TX_DV -> o_M_TX_DV is 1 cycle.
- TRANSFER, remaining=0 & master free (last byte fully shifted): on the next edge o_SPI_CS_n=1, gap counter=CS_INACTIVE_CLKS-1, go to CS_GAP.
- CS_GAP: decrement gap counter each cycle; at 0 go to IDLE. CS is high for exactly CS_INACTIVE_CLKS cycles before o_TX_Ready can assert.
- RX path, every state:
  - i_M_RX_DV=1 -> next edge o_RX_DV=1, o_RX_Byte=i_M_RX_Byte, o_RX_Count=current RX index; RX index increments (wraps modulo 2^CW).
  - o_RX_DV is 0 otherwise. RX latency is 1 cycle.
- Simultaneous events:
  - i_M_RX_DV and a TX accept on the same cycle are both serviced.
  - The final RX pulse of a transfer precedes the CS-high edge, because the byte master raises ready after its RX pulse.
- o_SPI_CS_n is registered and glitch-free. It never toggles inside a transfer.

Test Plan:
- Reset: hold i_Rst_L=0 for 3 cycles with i_TX_DV=1 -> o_SPI_CS_n=1, o_M_TX_DV=0, o_RX_DV=0, o_TX_Ready=0; release -> o_TX_Ready=1 once i_M_TX_Ready=1.
- Two-byte transfer (MAX=2): count=2, bytes 0xA5 then 0x3C, byte-master model loops MOSI->MISO -> CS low before the first o_M_TX_DV and high after the second byte; o_RX_Byte=0xA5 with o_RX_Count=0, then 0x3C with o_RX_Count=1; exactly 2 o_M_TX_DV pulses.
- CS gap: CS_INACTIVE_CLKS=4, back-to-back single-byte transfers with i_TX_DV held waiting -> CS high exactly 4 cycles between transfers; o_TX_Ready=0 throughout the gap.
- Count edge cases: i_TX_Count=0 -> no CS change, no o_M_TX_DV; i_TX_Count=3 with MAX=2 -> exactly 2 bytes sent under one CS low.
- Illegal DV: pulse i_TX_DV while the master is mid-byte (o_TX_Ready=0) -> no extra o_M_TX_DV; remaining count unchanged.
- Reset mid-transfer: assert i_Rst_L=0 after the first byte of a 2-byte transfer -> CS high on the next edge, state IDLE; a subsequent 1-byte transfer completes normally with o_RX_Count=0.
